// File: rtl/game_sequencer.sv
// Game mode sequencer for one Game & Watch core: idle/play/pause/over FSM,
// frame and beat strobes, score and miss bookkeeping, beat speed-up.
//
// state | meaning
// IDLE  | no game, core held in reset
// PLAY  | game running, strobes active, score/misses accepted
// PAUSE | game frozen, timing counters hold
// OVER  | miss limit reached, core held in reset until Start
module game_sequencer #(
    parameter int TPERF       = 3125000,
    parameter int FPERB_INIT  = 8,
    parameter int FPERB_MIN   = 2,
    parameter int SPEEDUP_PTS = 50,
    parameter int MAX_MISSES  = 3,
    parameter int SCORE_MAX   = 999
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Start,
    input  logic       Pause,
    input  logic       QuitReq,
    input  logic       Miss,
    input  logic       PtsValid,
    input  logic [2:0] Pts,
    output logic       FrameTick,
    output logic       BeatTick,
    output logic       CoreReset,
    output logic [1:0] State,
    output logic [9:0] Score,
    output logic [1:0] Misses,
    output logic [3:0] Fperb
);

    localparam int TW = (TPERF > 1) ? $clog2(TPERF) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TPERF - 1);
    localparam logic [1:0]    MISS_LAST = 2'(MAX_MISSES - 1);
    localparam logic [3:0]    FP_INIT   = 4'(FPERB_INIT);
    localparam logic [3:0]    FP_MIN    = 4'(FPERB_MIN);
    localparam logic [10:0]   SCORE_SAT = 11'(SCORE_MAX);
    localparam logic [15:0]   STEP      = 16'(SPEEDUP_PTS);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_t;

    state_t         state;
    logic [TW-1:0]  tick_cnt;
    logic           tick_wrap;
    logic [3:0]     frame_cnt;
    logic [3:0]     fperb;
    logic [9:0]     score;
    logic [1:0]     misses;
    logic [15:0]    threshold;
    logic           pending;
    logic           frame_tick;
    logic           beat_tick;
    logic           core_reset;

    logic           game_end;
    logic           play_hold;
    logic           frame_evt;
    logic           beat_evt;
    logic [10:0]    score_sum;
    logic [9:0]     score_next;
    logic           crossed;

    // Timing only advances on cycles that start and stay in PLAY.
    assign game_end   = Miss && (misses == MISS_LAST);
    assign play_hold  = (state == PLAY) && !QuitReq && !game_end && !Pause;
    assign frame_evt  = play_hold && tick_wrap;
    assign beat_evt   = frame_evt && (frame_cnt >= fperb - 4'd1);
    assign score_sum  = {1'b0, score} + {8'b0, Pts};
    assign score_next = (score_sum > SCORE_SAT) ? SCORE_SAT[9:0] : score_sum[9:0];
    assign crossed    = ({6'b0, score_next} >= threshold);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            tick_wrap  <= 1'b0;
            frame_cnt  <= 4'd0;
            fperb      <= FP_INIT;
            score      <= 10'd0;
            misses     <= 2'd0;
            threshold  <= STEP;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            beat_tick  <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            core_reset <= (state == IDLE) || (state == OVER);
            frame_tick <= frame_evt;
            beat_tick  <= beat_evt;

            if (play_hold) begin
                tick_cnt  <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
                tick_wrap <= (tick_cnt == TICK_LAST);
                if (frame_evt)
                    frame_cnt <= beat_evt ? 4'd0 : frame_cnt + 4'd1;
                if (beat_evt) begin
                    pending <= 1'b0;
                    if (pending && (fperb > FP_MIN))
                        fperb <= fperb - 4'd1;
                end
            end

            // A crossing on the beat edge re-arms pending for the following beat.
            if ((state == PLAY) && !QuitReq) begin
                if (Miss)
                    misses <= misses + 2'd1;
                if (PtsValid) begin
                    score <= score_next;
                    if (crossed) begin
                        threshold <= threshold + STEP;
                        pending   <= 1'b1;
                    end
                end
            end

            if (QuitReq) begin
                state     <= IDLE;
                tick_cnt  <= '0;
                tick_wrap <= 1'b0;
                frame_cnt <= 4'd0;
            end else begin
                case (state)
                    IDLE, OVER: begin
                        if (Start) begin
                            state     <= PLAY;
                            score     <= 10'd0;
                            misses    <= 2'd0;
                            fperb     <= FP_INIT;
                            threshold <= STEP;
                            pending   <= 1'b0;
                            tick_cnt  <= '0;
                            tick_wrap <= 1'b0;
                            frame_cnt <= 4'd0;
                        end
                    end
                    PLAY: begin
                        if (game_end)
                            state <= OVER;
                        else if (Pause)
                            state <= PAUSE;
                    end
                    PAUSE: begin
                        if (Pause)
                            state <= PLAY;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign FrameTick = frame_tick;
    assign BeatTick  = beat_tick;
    assign CoreReset = core_reset;
    assign State     = state;
    assign Score     = score;
    assign Misses    = misses;
    assign Fperb     = fperb;

endmodule
